// File: rtl/return_stack.sv
// Return-address stack for the 19-bit CPU: CALL saves PC+1, RET exposes it on top_addr.
// Overflow and underflow are sticky until reset; the stack never wraps.
module return_stack #(
   parameter int ADDR_W = 19,
   parameter int DEPTH  = 16,
   parameter int CNT_W  = $clog2(DEPTH+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic              pop,
   input  logic              stall,
   input  logic [ADDR_W-1:0] ret_addr_in,
   output logic [ADDR_W-1:0] top_addr,
   output logic [CNT_W-1:0]  count,
   output logic              empty,
   output logic              full,
   output logic              overflow,
   output logic              underflow
);

   // Lower entries only: the top lives in its own register, so the array holds DEPTH-1 words.
   localparam int LOW_N = DEPTH - 1;
   localparam int IDX_W = (LOW_N > 1) ? $clog2(LOW_N) : 1;

   logic [ADDR_W-1:0] stk [0:LOW_N-1];
   logic [ADDR_W-1:0] top_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              ovf_q, unf_q;

   logic              do_push, do_pop;
   logic              is_empty, is_full, has_two;
   logic [CNT_W-1:0]  cnt_m1, cnt_m2;
   logic [IDX_W-1:0]  wr_idx, rd_idx;
   logic [ADDR_W-1:0] below_top;
   logic              spill;

   assign do_push  = push & ~stall;
   assign do_pop   = pop  & ~stall;

   assign is_empty = (cnt_q == '0);
   assign is_full  = (cnt_q == CNT_W'(DEPTH));
   assign has_two  = (cnt_q >= CNT_W'(2));

   assign cnt_m1   = cnt_q - CNT_W'(1);
   assign cnt_m2   = cnt_q - CNT_W'(2);
   assign wr_idx   = cnt_m1[IDX_W-1:0];
   assign rd_idx   = cnt_m2[IDX_W-1:0];

   // Only a lone push onto a non-empty, non-full stack moves the old top down.
   assign spill    = do_push & ~do_pop & ~is_full & ~is_empty;

   always_comb begin
      below_top = '0;
      if (has_two) below_top = stk[rd_idx];
   end

   always_ff @(posedge clk) begin
      if (!rst && spill) stk[wr_idx] <= top_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         top_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else if (do_push && do_pop) begin
         // Replace the top; on an empty stack the pop half underflows but the push still lands.
         top_q <= ret_addr_in;
         if (is_empty) begin
            cnt_q <= CNT_W'(1);
            unf_q <= 1'b1;
         end
      end else if (do_push) begin
         if (is_full) begin
            ovf_q <= 1'b1;
         end else begin
            top_q <= ret_addr_in;
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end else if (do_pop) begin
         if (is_empty) begin
            unf_q <= 1'b1;
         end else begin
            top_q <= below_top;
            cnt_q <= cnt_m1;
         end
      end
   end

   assign top_addr  = top_q;
   assign count     = cnt_q;
   assign empty     = is_empty;
   assign full      = is_full;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule
